// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instruction words (plus mvi immediates) from program memory and issues them to the processor.
// Define SEQ_WATCHDOG_EN to abort a run when EXEC exceeds WDOG_CYCLES cycles without proc_done.
module prog_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int CNT_W       = 8,
    parameter int WDOG_CYCLES = 15
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  instr_count,
    output logic              busy,
    output logic              done_all,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       proc_din,
    output logic              proc_run,
    input  logic              proc_done
);
    typedef enum logic [2:0] {IDLE, FETCH_I, WAIT_I, FETCH_M, WAIT_M, ISSUE, EXEC, FIN} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] rem;
    logic [15:0] ir, imm;
    logic is_mvi, wd_to;
    assign is_mvi   = ir[15:13] == 3'b001;
    assign busy     = state != IDLE;
    assign done_all = state == FIN;
    assign mem_req  = state == FETCH_I || state == FETCH_M;
    assign mem_addr = mem_req ? pc : '0;
    assign proc_run = state == ISSUE;
    assign proc_din = state == ISSUE ? ir : state == EXEC ? (is_mvi ? imm : ir) : '0;
`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    assign wd_to = state == EXEC && !proc_done && wd_cnt == WD_W'(WDOG_CYCLES - 1);
    // counter is held at zero outside EXEC, so it restarts on every EXEC entry
    always_ff @(posedge clk or negedge Resetn)
        if (!Resetn) wd_cnt <= '0;
        else wd_cnt <= state == EXEC ? wd_cnt + 1'b1 : '0;
`else
    assign wd_to = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = instr_count == '0 ? FIN : FETCH_I;
            FETCH_I: state_nx = WAIT_I;
            WAIT_I:  if (mem_rvalid) state_nx = mem_rdata[15] ? FIN : mem_rdata[15:13] == 3'b001 ? FETCH_M : ISSUE;
            FETCH_M: state_nx = WAIT_M;
            WAIT_M:  if (mem_rvalid) state_nx = ISSUE;
            ISSUE:   state_nx = EXEC;
            EXEC:    state_nx = proc_done ? (rem == CNT_W'(1) ? FIN : FETCH_I) : wd_to ? FIN : EXEC;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            pc    <= '0;
            rem   <= '0;
            ir    <= '0;
            imm   <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                pc    <= base_addr;
                rem   <= instr_count;
                error <= 1'b0;
            end
            if (mem_req) pc <= pc + 1'b1;
            if (state == WAIT_I && mem_rvalid) begin
                ir <= mem_rdata;
                if (mem_rdata[15]) error <= 1'b1;
            end
            if (state == WAIT_M && mem_rvalid) imm <= mem_rdata;
            if (state == EXEC && proc_done) rem <= rem - 1'b1;
            if (wd_to) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scoreboard bench with random-latency memory, a processor model and a program-level reference.
// Define SEQ_WATCHDOG_EN to also exercise the EXEC timeout.
module tb_prog_sequencer;
    logic clk = 0, Resetn = 0, start = 0;
    logic [7:0] base_addr = 0, instr_count = 0;
    logic busy, done_all, error, mem_req, mem_rvalid, proc_run, proc_done;
    logic [7:0] pc, mem_addr;
    logic [15:0] mem_rdata, proc_din;
    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk(clk), .Resetn(Resetn), .start(start), .base_addr(base_addr), .instr_count(instr_count),
        .busy(busy), .done_all(done_all), .error(error), .pc(pc), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .proc_din(proc_din), .proc_run(proc_run),
        .proc_done(proc_done)
    );

    int total = 0, bad = 0;
    logic [15:0] mem [256];
    logic [15:0] rr [8];
    logic [7:0] exp_addr [$];
    logic [15:0] exp_run [$];
    logic [8:0] exp_end [$];
    logic [127:0] exp_regs [$];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    function automatic logic [127:0] pk(input logic [15:0] r [8]);
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = r[i];
        return v;
    endfunction

    // memory: one outstanding read, 1..3 cycle latency, garbage data when not valid
    logic pend;
    int lat;
    logic [7:0] raddr;
    always_ff @(posedge clk or negedge Resetn)
        if (!Resetn) begin
            pend <= 0; lat <= 0; raddr <= 0; mem_rvalid <= 0; mem_rdata <= 0;
        end else begin
            mem_rvalid <= 0;
            mem_rdata <= 16'($urandom);
            if (mem_req) begin
                pend <= 1; lat <= $urandom_range(0, 2); raddr <= mem_addr;
            end else if (pend) begin
                if (lat == 0) begin
                    pend <= 0; mem_rvalid <= 1; mem_rdata <= mem[raddr];
                end else lat <= lat - 1;
            end
        end

    // processor: mv/mvi finish in the first cycle after Run, add/sub in the third
    logic [15:0] R [8];
    logic [15:0] pir;
    int step;
    logic hang = 0;
    assign proc_done = !hang && ((step == 1 && pir[15:14] == 2'b00) || (step == 3 && pir[15:14] == 2'b01));
    always_ff @(posedge clk or negedge Resetn)
        if (!Resetn) begin
            step <= 0; pir <= 0;
            for (int i = 0; i < 8; i++) R[i] <= 0;
        end else if (proc_run) begin
            pir <= proc_din; step <= 1;
        end else if (proc_done) begin
            step <= 0;
            case (pir[15:13])
                3'd0: R[pir[12:10]] <= R[pir[9:7]];
                3'd1: R[pir[12:10]] <= proc_din;
                3'd2: R[pir[12:10]] <= R[pir[12:10]] + R[pir[9:7]];
                default: R[pir[12:10]] <= R[pir[12:10]] - R[pir[9:7]];
            endcase
        end else if (step != 0) step <= step + 1;

    // program-level reference: walk the memory image and predict every observable event
    task automatic ref_run(input logic [7:0] b, input logic [7:0] n);
        logic [7:0] p;
        logic e;
        logic [15:0] w, v;
        p = b; e = 0;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(p); w = mem[p]; p++;
            if (w[15]) begin e = 1; break; end
            v = 0;
            if (w[15:13] == 3'd1) begin exp_addr.push_back(p); v = mem[p]; p++; end
            exp_run.push_back(w);
            case (w[15:13])
                3'd0: rr[w[12:10]] = rr[w[9:7]];
                3'd1: rr[w[12:10]] = v;
                3'd2: rr[w[12:10]] = rr[w[12:10]] + rr[w[9:7]];
                default: rr[w[12:10]] = rr[w[12:10]] - rr[w[9:7]];
            endcase
        end
        exp_end.push_back({e, p});
        exp_regs.push_back(pk(rr));
    endtask

    always @(negedge clk) if (Resetn) begin
        if (mem_req) begin
            chk("mem_req_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) chk("mem_addr", mem_addr, exp_addr.pop_front());
        end
        if (proc_run) begin
            chk("proc_run_expected", exp_run.size() != 0, 1);
            if (exp_run.size() != 0) chk("proc_din_issue", proc_din, exp_run.pop_front());
        end
        if (done_all) begin
            chk("done_all_expected", exp_end.size() != 0, 1);
            if (exp_end.size() != 0) begin
                chk("end_error_pc", {error, pc}, exp_end.pop_front());
                chk("end_regs", pk(R), exp_regs.pop_front());
            end
        end
    end

    task automatic run(input logic [7:0] b, input logic [7:0] n, input bit use_ref);
        int k;
        @(negedge clk);
        base_addr = b; instr_count = n; start = 1;
        if (use_ref) ref_run(b, n);
        @(negedge clk);
        start = 0; k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
            // stray starts while busy must be ignored
            start = busy && $urandom_range(0, 7) == 0;
            base_addr = 8'($urandom); instr_count = 8'($urandom);
        end
        start = 0;
        chk("run_finished", k < 3000, 1);
        chk("queues_drained", exp_addr.size() + exp_run.size() + exp_end.size(), 0);
    endtask

    initial begin
        logic [7:0] a, b;
        logic [15:0] w;
        int n, k;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) rr[i] = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done_all, error, pc, mem_req, mem_addr, proc_din, proc_run}, 0);
        Resetn = 1;

        mem[8'h10] = 16'h2000; mem[8'h11] = 16'h0005;
        run(8'h10, 1, 1);
        chk("t1_pc", pc, 8'h12);
        chk("t1_r0", R[0], 16'h0005);

        mem[8'h20] = 16'h2400; mem[8'h21] = 16'h0003; mem[8'h22] = 16'h2800;
        mem[8'h23] = 16'h0004; mem[8'h24] = 16'h4500;
        run(8'h20, 3, 1);
        chk("t2_r1", R[1], 16'h0007);
        chk("t2_pc", pc, 8'h25);

        @(negedge clk);
        base_addr = 8'h30; instr_count = 0; start = 1;
        ref_run(8'h30, 0);
        @(negedge clk);
        start = 0;
        chk("t3_done_next", done_all, 1);
        chk("t3_busy_one", busy, 1);
        @(negedge clk);
        chk("t3_idle", busy, 0);

        mem[8'h40] = 16'h8000;
        run(8'h40, 1, 1);
        chk("t4_error", error, 1);
        mem[8'h50] = 16'h0080;
        run(8'h50, 1, 1);
        chk("t4_error_cleared", error, 0);

        mem[8'hFF] = 16'h2C00; mem[8'h00] = 16'h1234;
        run(8'hFF, 1, 1);
        chk("t5_pc_wrap", pc, 8'h01);

        for (int t = 0; t < 25; t++) begin
            b = 8'($urandom); a = b; n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                w[15:13] = $urandom_range(0, 15) == 0 ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                mem[a] = w; a++;
                if (w[15:13] == 3'd1) begin mem[a] = 16'($urandom); a++; end
            end
            run(b, 8'(n), 1);
        end

        // reset in the first EXEC cycle of a sub
        mem[8'h60] = 16'h6280;
        @(negedge clk);
        base_addr = 8'h60; instr_count = 1; start = 1;
        ref_run(8'h60, 1);
        @(negedge clk);
        start = 0; k = 0;
        while (!proc_run && k < 100) begin @(negedge clk); k++; end
        chk("t6_reached_issue", k < 100, 1);
        @(negedge clk);
        chk("t6_exec_din", proc_din, 16'h6280);
        #1 Resetn = 0;
        #1 chk("t6_async_reset", {busy, done_all, error, pc, mem_req, mem_addr, proc_din, proc_run}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_done", done_all, 0);
        end
        exp_addr.delete(); exp_run.delete(); exp_end.delete(); exp_regs.delete();
        for (int i = 0; i < 8; i++) rr[i] = 0;
        Resetn = 1;
        mem[8'h61] = 16'h2400; mem[8'h62] = 16'hBEEF;
        run(8'h61, 1, 1);
        chk("t6_after_reset_pc", pc, 8'h63);

`ifdef SEQ_WATCHDOG_EN
        mem[8'h70] = 16'h0080;
        hang = 1;
        exp_addr.push_back(8'h70);
        exp_run.push_back(16'h0080);
        exp_end.push_back({1'b1, 8'h71});
        exp_regs.push_back(pk(rr));
        run(8'h70, 1, 0);
        hang = 0;
        chk("wd_error", error, 1);
        run(8'h61, 1, 1);
        chk("wd_error_cleared", error, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Instruction-stream controller for the 16-bit bus processor. It fetches instruction words from a program memory starting at a given address and presents each one on the processor's DIN with a one-cycle Run pulse. For mvi it also supplies the immediate word, then waits for the processor's Done before fetching the next instruction. It is the only driver of the processor's DIN and Run, and it shares clk and Resetn with the processor.

Parameters:
ADDR_W, 8, program memory address width; pc wraps modulo 2^ADDR_W
CNT_W, 8, width of the instruction count
WDOG_CYCLES, 15, max cycles in EXEC before timeout (used only with SEQ_WATCHDOG_EN)

Ports:
clk  in  1  system clock, all state on rising edge
Resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; launches a program run (IDLE only)
base_addr  in  ADDR_W  first instruction address, sampled on start
instr_count  in  CNT_W  number of instructions to run, sampled on start
busy  out  1  high in any state other than IDLE
done_all  out  1  one-cycle pulse when a run ends, normal or error
error  out  1  sticky; set on illegal opcode or timeout, cleared on accepted start
pc  out  ADDR_W  address of the next word to fetch
mem_req  out  1  one-cycle read request
mem_addr  out  ADDR_W  read address, valid with mem_req
mem_rvalid  in  1  read data valid, any latency of 1 cycle or more
mem_rdata  in  16  read data
proc_din  out  16  to processor DIN
proc_run  out  1  to processor Run
proc_done  in  1  from processor Done (combinational, sampled at clk edge)

Behaviour:
- Reset values: busy=0, done_all=0, error=0, pc=0, mem_req=0, mem_addr=0, proc_din=0, proc_run=0. State goes to IDLE. The remaining-count and instruction/immediate registers are cleared.
- Reset mid-operation aborts immediately. No done_all pulse is produced, and any in-flight mem_rvalid after reset is ignored.
- Instruction word format: opcode=[15:13], X=[12:10], Y=[9:7]. Opcodes: 000 mv, 001 mvi, 010 add, 011 sub. Opcodes 1xx are illegal.
- IDLE: when start=1, latch pc=base_addr and rem=instr_count, and clear error.
  - If instr_count=0, go to FIN; no memory access occurs.
  - Otherwise go to FETCH_I.
  - start is ignored in every state except IDLE.
- FETCH_I: mem_req=1 and mem_addr=pc for exactly one cycle; pc<=pc+1; go to WAIT_I.
- WAIT_I: on mem_rvalid, latch ir=mem_rdata.
  - Illegal opcode: set error, go to FIN.
  - mvi: go to FETCH_M.
  - Otherwise: go to ISSUE.
- FETCH_M / WAIT_M: same handshake as FETCH_I / WAIT_I (pc increments again). On mem_rvalid, latch imm and go to ISSUE.
- ISSUE (1 cycle): proc_din=ir and proc_run=1 while the processor is in T0, so it latches IR. Go to EXEC.
- EXEC: proc_run=0. proc_din=imm for mvi, ir otherwise, held constant for the whole state.
  - Wait for proc_done=1; expected in the first EXEC cycle for mv/mvi and the third for add/sub.
  - On proc_done: rem<=rem-1. If rem=1, go to FIN; otherwise go to FETCH_I.
- FIN (1 cycle): done_all=1, go to IDLE.
- mem_rvalid outside WAIT_I/WAIT_M is ignored. Only one read is ever outstanding.
- pc wraps from 2^ADDR_W-1 to 0 without error. An mvi immediate may sit at address 0 after the wrap.
- Throughput: instruction latency = 2 + L + 1 + E cycles (+2+L for mvi), where L is memory latency and E is execution cycles. No overlap between fetch and execution.

Optional Feature:
SEQ_WATCHDOG_EN:
- Defined: an EXEC-cycle counter clears on EXEC entry. If proc_done has not been seen after WDOG_CYCLES cycles, set error and go to FIN.
- Not defined: no counter; EXEC waits indefinitely for proc_done.

Test Plan:
1. Memory {0x2000 mvi R0, 0x0005} at base 0x10, count=1, L=1 -> proc_run high 1 cycle with proc_din=0x2000; next cycle proc_din=0x0005 and proc_done=1; done_all pulses; pc=0x12; error=0.
2. Program mvi R1,#3; mvi R2,#4; add R1,R2 (0x2400,0x0003,0x2800,0x0004,0x4500), count=3 -> exactly 3 proc_run pulses; R1 ends at 7; 5 mem_req pulses; pc=base+5.
3. instr_count=0 with start -> done_all one cycle after start; mem_req never asserted; busy high for exactly 1 cycle.
4. Word 0x8000 fetched (illegal opcode 100) -> error=1, done_all pulses, proc_run never asserted. A subsequent valid start clears error.
5. base_addr=0xFF, count=1, mvi with immediate at 0x00 -> mem_addr sequence 0xFF, 0x00; pc=0x01 at end.
6. Resetn low during EXEC of a sub -> all outputs at reset values within the same cycle; no done_all. With SEQ_WATCHDOG_EN and proc_done tied 0: error after 15 EXEC cycles, then done_all.
